// File: rtl/g3f_deadtime_if.sv
// Bundle of control, phase-level and gate-drive signals between the g3f
// generator side and the dead-time stage.
interface g3f_deadtime_if #(
  parameter int DT_W = 4
);
  // No valid/ready pairing: every input is a level sampled on each clk edge,
  // and every output is a level decoded from registered state.
  logic            en;
  logic [DT_W-1:0] dt;
  logic            qa;
  logic            qb;
  logic            qc;
  logic            fault;
  logic            fault_clr;
  logic            ah;
  logic            al;
  logic            bh;
  logic            bl;
  logic            ch;
  logic            cl;
  logic            fault_latched;
  logic            busy;
  logic [5:0]      state_dbg;

  modport master (
    output en, dt, qa, qb, qc, fault, fault_clr,
    input  ah, al, bh, bl, ch, cl, fault_latched, busy, state_dbg
  );

  modport slave (
    input  en, dt, qa, qb, qc, fault, fault_clr,
    output ah, al, bh, bl, ch, cl, fault_latched, busy, state_dbg
  );
endinterface

// File: rtl/g3f_deadtime.sv
// Three-phase complementary gate driver with programmable dead time,
// enable gating and a sticky fault shutdown.
module g3f_deadtime #(
  parameter int DT_W = 4
) (
  input logic           clk,
  input logic           rst,
  g3f_deadtime_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic [2:0]            q_r;
  logic                  fault_latched;
  logic [2:0][1:0]       state;
  logic [2:0][DT_W-1:0]  cnt;
  logic [2:0]            tgt;
  logic [DT_W-1:0]       dead_load;
  logic                  force_idle;

  // A dead time of zero still needs one cycle, so the reload is max(dt,1)-1.
  assign dead_load  = (bus.dt == '0) ? '0 : bus.dt - DT_W'(1);
  assign force_idle = fault_latched | bus.fault | ~bus.en;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r           <= '0;
      fault_latched <= 1'b0;
      state         <= {3{ST_IDLE}};
      cnt           <= '0;
      tgt           <= '0;
    end else begin
      q_r <= {bus.qc, bus.qb, bus.qa};

      // Fault set dominates a simultaneous clear.
      if (bus.fault) begin
        fault_latched <= 1'b1;
      end else if (bus.fault_clr) begin
        fault_latched <= 1'b0;
      end

      for (int i = 0; i < 3; i++) begin
        if (force_idle) begin
          state[i] <= ST_IDLE;
          cnt[i]   <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              state[i] <= ST_DEAD;
              tgt[i]   <= q_r[i];
              cnt[i]   <= dead_load;
            end
            ST_HIGH: begin
              if (!q_r[i]) begin
                state[i] <= ST_DEAD;
                tgt[i]   <= 1'b0;
                cnt[i]   <= dead_load;
              end
            end
            ST_LOW: begin
              if (q_r[i]) begin
                state[i] <= ST_DEAD;
                tgt[i]   <= 1'b1;
                cnt[i]   <= dead_load;
              end
            end
            ST_DEAD: begin
              // A level change mid-dead-time restarts the full gap.
              if (q_r[i] != tgt[i]) begin
                tgt[i] <= q_r[i];
                cnt[i] <= dead_load;
              end else if (cnt[i] == '0) begin
                state[i] <= tgt[i] ? ST_HIGH : ST_LOW;
              end else begin
                cnt[i] <= cnt[i] - DT_W'(1);
              end
            end
            default: begin
              state[i] <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.ah = (state[0] == ST_HIGH);
  assign bus.al = (state[0] == ST_LOW);
  assign bus.bh = (state[1] == ST_HIGH);
  assign bus.bl = (state[1] == ST_LOW);
  assign bus.ch = (state[2] == ST_HIGH);
  assign bus.cl = (state[2] == ST_LOW);

  assign bus.busy          = (state[0] == ST_DEAD) | (state[1] == ST_DEAD) | (state[2] == ST_DEAD);
  assign bus.fault_latched = fault_latched;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_g3f_deadtime.sv
// Bench for g3f_deadtime: directed vectors through a scoreboard queue, then
// randomised shoot-through and dead-gap monitoring.
module tb_g3f_deadtime;
  localparam int DT_W = 4;
  localparam int W    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  g3f_deadtime_if #(.DT_W(DT_W)) bus ();

  g3f_deadtime #(.DT_W(DT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_pass  = 0;
  int           n_total = 0;
  logic         rnd_on  = 1'b0;
  int           rand_d  = 1;

  logic [W-1:0] mon_exp;
  string        mon_name;
  logic [1:0]   cur_hl[3];
  logic [1:0]   prv_hl[3];
  int           run_lo[3] = '{0, 0, 0};

  task automatic chk(input string name, input logic ok, input int act, input int req);
    n_total++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.ah, bus.al, bus.bh, bus.bl, bus.ch, bus.cl, bus.fault_latched, bus.busy};
  endfunction

  // ---------------- driver tasks ----------------
  // Vector order: {ah, al, bh, bl, ch, cl, fault_latched, busy} after the next edge.
  task automatic step(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      chk(mon_name, obs() === mon_exp, int'(obs()), int'(mon_exp));
    end
    cur_hl[0] = {bus.ah, bus.al};
    cur_hl[1] = {bus.bh, bus.bl};
    cur_hl[2] = {bus.ch, bus.cl};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("shoot_through_%0d", i), cur_hl[i] !== 2'b11, int'(cur_hl[i]), 0);
      if (rnd_on && (cur_hl[i] == 2'b10 || cur_hl[i] == 2'b01) && cur_hl[i] !== prv_hl[i])
        chk($sformatf("dead_gap_%0d", i), run_lo[i] >= rand_d, run_lo[i], rand_d);
      if (cur_hl[i] == 2'b00) run_lo[i]++;
      else run_lo[i] = 0;
      prv_hl[i] = cur_hl[i];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.dt = 4'd3;
    bus.qa = 1'b1; bus.qb = 1'b0; bus.qc = 1'b0;
    bus.fault = 1'b0; bus.fault_clr = 1'b0;

    // reset, load q_r with en low, then enable: 3 dead cycles, then A high, B/C low
    step("reset", 8'b0000_0000);
    step("reset", 8'b0000_0000);
    rst = 1'b0;
    step("q_load", 8'b0000_0000);
    bus.en = 1'b1;
    repeat (3) step("en_dead", 8'b0000_0001);
    step("en_drive", 8'b1001_0100);

    // steady A fall, dt=2
    bus.dt = 4'd2; bus.qa = 1'b0;
    step("a_fall_k", 8'b1001_0100);
    repeat (2) step("a_fall_dead", 8'b0001_0101);
    step("a_fall_low", 8'b0101_0100);

    // dt=0 boundary on B rise: single dead cycle
    bus.dt = 4'd0; bus.qb = 1'b1;
    step("b_dt0_k", 8'b0101_0100);
    step("b_dt0_dead", 8'b0100_0101);
    step("b_dt0_high", 8'b0110_0100);

    // glitch on A during dead time, dt change after retarget is ignored
    bus.qa = 1'b1; bus.dt = 4'd4;
    step("glitch_k", 8'b0110_0100);
    repeat (2) step("glitch_dead1", 8'b0010_0101);
    bus.qa = 1'b0;
    repeat (2) step("glitch_retgt", 8'b0010_0101);
    bus.dt = 4'd1;
    repeat (3) step("glitch_dead2", 8'b0010_0101);
    step("glitch_low", 8'b0110_0100);

    // fault latch, fault+clr together, clear, full dead time before resume
    bus.fault = 1'b1;
    step("fault_set", 8'b0000_0010);
    bus.fault = 1'b0;
    step("fault_hold", 8'b0000_0010);
    bus.fault = 1'b1; bus.fault_clr = 1'b1;
    step("fault_vs_clr", 8'b0000_0010);
    bus.fault = 1'b0; bus.fault_clr = 1'b0;
    step("fault_hold2", 8'b0000_0010);
    bus.fault_clr = 1'b1;
    step("fault_clear", 8'b0000_0000);
    bus.fault_clr = 1'b0; bus.dt = 4'd2;
    repeat (2) step("fault_dead", 8'b0000_0001);
    step("fault_resume", 8'b0110_0100);

    // en drop mid-dead aborts, re-enable restarts a full dead time
    bus.qc = 1'b1;
    step("en_abort_k", 8'b0110_0100);
    step("en_abort_dead", 8'b0110_0001);
    bus.en = 1'b0;
    step("en_abort_idle", 8'b0000_0000);
    bus.en = 1'b1;
    repeat (2) step("en_redead", 8'b0000_0001);
    step("en_redrive", 8'b0110_1000);

    // reset mid-operation, then retarget out of the zeroed q_r
    rst = 1'b1;
    step("rst_mid", 8'b0000_0000);
    rst = 1'b0;
    step("rst_dead0", 8'b0000_0001);
    step("rst_retgt", 8'b0000_0001);
    step("rst_a_low", 8'b0100_0001);
    step("rst_bc_high", 8'b0110_1000);

    // randomised shoot-through / dead-gap soak
    for (int c = 0; c < 20; c++) begin
      rst = 1'b0; bus.en = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b1;
      idle_step();
      idle_step();
      bus.dt = DT_W'($urandom_range(0, 15));
      rand_d = (bus.dt == '0) ? 1 : int'(bus.dt);
      bus.fault_clr = 1'b0;
      rnd_on = 1'b1;
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, 9) == 0) bus.qa = ~bus.qa;
        if ($urandom_range(0, 9) == 0) bus.qb = ~bus.qb;
        if ($urandom_range(0, 9) == 0) bus.qc = ~bus.qc;
        bus.en        = ($urandom_range(0, 49) != 0);
        bus.fault     = ($urandom_range(0, 99) == 0);
        bus.fault_clr = ($urandom_range(0, 9) == 0);
        rst           = ($urandom_range(0, 199) == 0);
        idle_step();
      end
    end
    rnd_on = 1'b0;
    rst = 1'b0;

    // drain the expected queue with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle_step();
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
